// File: rtl/shift_pkg.sv
// Shared shift-mode encoding and fill rule for the pipelined barrel shifter and the ALU model.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package shift_pkg;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10,
        SH_ROR = 2'b11
    } shift_op_e;

    // Value entering a vacated MSB position on a right shift.
    // SRL fills with zero, SRA with the sign of the original operand, and ROR
    // with the bit that just fell off the LSB end. SLL never vacates MSBs.
    function automatic logic fill_bit(shift_op_e op, logic sign, logic wrap);
        logic f;
        case (op)
            SH_SRA:  f = sign;
            SH_ROR:  f = wrap;
            default: f = 1'b0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One barrel layer: conditional shift by DIST followed by a pipeline register.
// Latency: 1 cycle.
// Backpressure: holds while valid and downstream not ready; an empty stage always loads.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4,
    parameter int DIST  = 1,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             prev_valid,
    output logic             prev_ready,
    input  logic [WIDTH-1:0] prev_data,
    input  logic [SHW-1:0]   prev_amt,
    input  logic [1:0]       prev_op,
    input  logic [TAG_W-1:0] prev_tag,
    input  logic             prev_sign,
    output logic             valid,
    input  logic             next_ready,
    output logic [WIDTH-1:0] data,
    output logic [SHW-1:0]   amt,
    output logic [1:0]       op,
    output logic [TAG_W-1:0] tag,
    output logic             sign
);

    // Amount bit that selects this layer's shift distance.
    localparam int BIT = $clog2(DIST);

    shift_op_e        mode;
    logic [WIDTH-1:0] rot;
    logic [WIDTH-1:0] shifted;

    assign mode = shift_op_e'(prev_op);
    assign rot  = {prev_data[DIST-1:0], prev_data[WIDTH-1:DIST]};

    // Accept when empty or when our current contents move on this cycle.
    assign prev_ready = !valid || next_ready;

    // One mux layer: left shifts zero-fill the LSBs; right shifts start from the
    // rotated word and overwrite the vacated MSBs according to the mode.
    always_comb begin
        shifted = prev_data;
        if (prev_amt[BIT]) begin
            if (mode == SH_SLL) begin
                shifted = prev_data << DIST;
            end else begin
                shifted = rot;
                for (int i = WIDTH - DIST; i < WIDTH; i++) begin
                    shifted[i] = fill_bit(mode, prev_sign, rot[i]);
                end
            end
        end
    end

    // Pipeline register; payload is captured only for a real transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            amt   <= '0;
            op    <= '0;
            tag   <= '0;
            sign  <= 1'b0;
        end else if (prev_ready) begin
            valid <= prev_valid;
            if (prev_valid) begin
                data <= shifted;
                amt  <= prev_amt;
                op   <= prev_op;
                tag  <= prev_tag;
                sign <= prev_sign;
            end
        end
    end

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR) with pass-through tag, one stage per amount bit.
// Latency: SHW cycles from accept to out_valid with no stall; one result per cycle.
// Backpressure: valid/ready chain; in_ready is combinational from out_ready and stage valids only.
module barrel_shift_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero
);

    // Reject widths the stage structure cannot represent.
    if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("barrel_shift_pipe: WIDTH must be a power of 2 and >= 4");
    end

    // Index k is the input side of stage k; index SHW is the pipe output.
    logic             valid_w [0:SHW];
    logic             ready_w [0:SHW];
    logic [WIDTH-1:0] data_w  [0:SHW];
    logic [SHW-1:0]   amt_w   [0:SHW];
    logic [1:0]       op_w    [0:SHW];
    logic [TAG_W-1:0] tag_w   [0:SHW];
    logic             sign_w  [0:SHW];

    assign valid_w[0]   = in_valid;
    assign data_w[0]    = in_data;
    assign amt_w[0]     = in_amt;
    assign op_w[0]      = in_op;
    assign tag_w[0]     = in_tag;
    assign sign_w[0]    = in_data[WIDTH-1];
    assign in_ready     = ready_w[0];
    assign ready_w[SHW] = out_ready;

    // Largest distance first: stage k handles amount bit SHW-1-k.
    for (genvar k = 0; k < SHW; k++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .TAG_W (TAG_W),
            .DIST  (1 << (SHW - 1 - k))
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .prev_valid (valid_w[k]),
            .prev_ready (ready_w[k]),
            .prev_data  (data_w[k]),
            .prev_amt   (amt_w[k]),
            .prev_op    (op_w[k]),
            .prev_tag   (tag_w[k]),
            .prev_sign  (sign_w[k]),
            .valid      (valid_w[k+1]),
            .next_ready (ready_w[k+1]),
            .data       (data_w[k+1]),
            .amt        (amt_w[k+1]),
            .op         (op_w[k+1]),
            .tag        (tag_w[k+1]),
            .sign       (sign_w[k+1])
        );
    end

    assign out_valid = valid_w[SHW];
    assign out_data  = data_w[SHW];
    assign out_tag   = tag_w[SHW];
    assign out_zero  = valid_w[SHW] && (data_w[SHW] == '0);

    // Control fields are spent by the time a result reaches the output.
    logic unused_tail;
    assign unused_tail = ^{amt_w[SHW], op_w[SHW], sign_w[SHW]};

endmodule

// File: tb/tb_barrel_shift_pipe.sv
module tb_barrel_shift_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_amt;
    logic [1:0]  in_op;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  out_tag;
    logic        out_zero;

    barrel_shift_pipe #(.WIDTH(16), .TAG_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  tag;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   pops  = 0;
    int   accepts = 0;
    int   first_pop = -1;
    int   last_pop  = -1;

    // Reference: plain arithmetic on the whole word, no layering.
    function automatic logic [15:0] model(logic [15:0] d, logic [3:0] a, logic [1:0] op);
        logic [31:0] dd;
        logic [15:0] r;
        case (op)
            2'b00:   r = d << a;
            2'b01:   r = d >> a;
            2'b10:   r = 16'($signed(d) >>> a);
            default: begin dd = {d, d} >> a; r = dd[15:0]; end
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: handshakes are evaluated at the falling edge, then we return 1ns after the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (rst_n && out_valid && out_ready) begin
            chk("pop_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_data", 32'(out_data), 32'(e.data));
                chk("sb_tag",  32'(out_tag),  32'(e.tag));
                chk("sb_zero", 32'(out_zero), 32'(e.data == 16'h0));
            end
            pops++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
        if (rst_n && in_valid && in_ready) begin
            e.data = model(in_data, in_amt, in_op);
            e.tag  = in_tag;
            exp_q.push_back(e);
            accepts++;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && (exp_q.size() != 0 || out_valid); i++) tick();
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic drive_rand(input logic [3:0] tag);
        in_data = 16'($urandom);
        in_amt  = 4'($urandom_range(0, 15));
        in_op   = 2'($urandom_range(0, 3));
        in_tag  = tag;
    endtask

    // Single transaction into an empty pipe; checks latency and the hand-derived result.
    task automatic run_one(input string name, input logic [15:0] d, input logic [3:0] a,
                           input logic [1:0] op, input logic [3:0] tag,
                           input logic [15:0] exp, input logic exp_zero);
        int lat;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = d;
        in_amt    = a;
        in_op     = op;
        in_tag    = tag;
        tick();
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        lat = 1;
        while (!out_valid && lat < 12) begin
            tick();
            lat++;
        end
        chk({name, "_latency"}, 32'(lat), 32'd4);
        chk({name, "_data"},    32'(out_data), 32'(exp));
        chk({name, "_tag"},     32'(out_tag),  32'(tag));
        chk({name, "_zero"},    32'(out_zero), 32'(exp_zero));
        tick();
        chk({name, "_gone"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [15:0] held_d;
        logic [3:0]  held_t;
        int          base_pops;
        int          base_acc;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_amt = '0; in_op = '0; in_tag = '0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_tag",   32'(out_tag),   32'd0);
        chk("rst_out_zero",  32'(out_zero),  32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        tick();

        // Directed modes and boundaries
        run_one("sra_8000_15", 16'h8000, 4'd15, 2'b10, 4'd1, 16'hFFFF, 1'b0);
        run_one("sra_7ff0_4",  16'h7FF0, 4'd4,  2'b10, 4'd2, 16'h07FF, 1'b0);
        run_one("ror_1234_4",  16'h1234, 4'd4,  2'b11, 4'd3, 16'h4123, 1'b0);
        run_one("ror_0001_1",  16'h0001, 4'd1,  2'b11, 4'd4, 16'h8000, 1'b0);
        run_one("sll_0001_15", 16'h0001, 4'd15, 2'b00, 4'd5, 16'h8000, 1'b0);
        run_one("srl_8000_15", 16'h8000, 4'd15, 2'b01, 4'd6, 16'h0001, 1'b0);
        run_one("sll_ffff_0",  16'hFFFF, 4'd0,  2'b00, 4'd7, 16'hFFFF, 1'b0);
        run_one("ror_a5c3_0",  16'hA5C3, 4'd0,  2'b11, 4'd8, 16'hA5C3, 1'b0);
        run_one("zero_sll_12", 16'h00F0, 4'd12, 2'b00, 4'd9, 16'h0000, 1'b1);
        run_one("zero_sll_8",  16'h00F0, 4'd8,  2'b00, 4'hA, 16'hF000, 1'b0);

        // Back-to-back: 16 transactions, tags 0..15, results on consecutive cycles
        drain();
        base_pops = pops; base_acc = accepts; first_pop = -1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive_rand(4'(i));
            tick();
        end
        drain();
        chk("b2b_accepts", 32'(accepts - base_acc), 32'd16);
        chk("b2b_pops",    32'(pops - base_pops),   32'd16);
        chk("b2b_consecutive", 32'(last_pop - first_pop), 32'd15);

        // Backpressure: fill with out_ready low, hold 5 cycles, then release
        base_acc = accepts; base_pops = pops;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive_rand(4'($urandom));
            tick();
        end
        chk("bp_fill_accepts", 32'(accepts - base_acc), 32'd4);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        chk("bp_out_valid",    32'(out_valid), 32'd1);
        held_d = out_data;
        held_t = out_tag;
        for (int i = 0; i < 5; i++) begin
            drive_rand(4'($urandom));
            tick();
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_data",  32'(out_data),  32'(held_d));
            chk("bp_hold_tag",   32'(out_tag),   32'(held_t));
            chk("bp_hold_ready", 32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_full_accept_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive_rand(4'($urandom));
            tick();
        end
        drain();
        chk("bp_no_loss", 32'(pops - base_pops), 32'(accepts - base_acc));

        // Random traffic with random stalls on both sides
        base_acc = accepts; base_pops = pops;
        for (int i = 0; i < 200; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            drive_rand(4'($urandom));
            tick();
        end
        drain();
        chk("rand_no_loss", 32'(pops - base_pops), 32'(accepts - base_acc));

        // Reset mid-flight with 3 transactions in the pipe
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_rand(4'(i));
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("mid_pre_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid_drop", 32'(out_valid), 32'd0);
        chk("mid_rst_data",       32'(out_data),  32'd0);
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("mid_rel_in_ready", 32'(in_ready),  32'd1);
        chk("mid_rel_valid",    32'(out_valid), 32'd0);
        base_pops = pops;
        for (int i = 0; i < 6; i++) tick();
        chk("mid_no_ghosts", 32'(pops - base_pops), 32'd0);
        run_one("post_rst", 16'hC3A5, 4'd3, 2'b10, 4'hE, 16'hF874, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop if the sequence above ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
